uart_rx_sequencer: RTL and testbench
====================================

# uart_rx_sequencer

Bit-timing controller that sits in front of the `mkuart_rx` byte deserializer. It oversamples an asynchronous serial line and detects and validates the start bit. It then feeds each mid-bit sample into the deserializer through its `EN_recieve`/`recieve_rx` handshake, checks the stop bit, and pops the assembled byte through `EN_get`. Completed bytes are presented on a one-entry valid/ready output register to the downstream consumer.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4.
- `CLK` input 1: sole clock; all state is updated on its rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `rx_line` input 1: raw serial line, idle high, asynchronous to `CLK`.
- `deser_bit` output 1: sample bit; drives the deserializer's `recieve_rx`.
- `deser_en` output 1: one-cycle push strobe; drives `EN_recieve`.
- `deser_rdy` input 1: deserializer's `RDY_recieve`.
- `deser_get_en` output 1: pop strobe; drives `EN_get`.
- `deser_get_rdy` input 1: `RDY_get`.
- `deser_data` input 8: `get` value; valid in the same cycle as `deser_get_en`.
- `byte_out` output 8: received byte.
- `byte_valid` output 1: `byte_out` holds an unconsumed byte.
- `byte_ready` input 1: consumer accepts the byte when high together with `byte_valid`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun_err` output 1: one-cycle pulse when a byte is dropped.
- `parity_err` output 1: one-cycle pulse on parity mismatch; constant 0 without the macro.
- `busy` output 1: FSM is not in IDLE.

## Operation
- `rx_line` passes through a 2-flop synchronizer (reset value 1); the FSM sees only the synchronized value `rxs`.
- FSM states are IDLE, START, DATA, PARITY (macro only), STOP and FETCH.
- **IDLE:** `rxs` = 0 → START; the bit counter and cycle counter clear.
- **START:** wait `CLKS_PER_BIT/2` cycles, then sample.
  - `rxs` = 1 → false start; return to IDLE with no pulses.
  - Otherwise → DATA.
- **DATA:** every `CLKS_PER_BIT` cycles, sample `rxs` and issue the push.
  - At the sample cycle, `deser_en` = 1 and `deser_bit` = the sample, for exactly one cycle.
  - If `deser_rdy` = 0 in the sample cycle, pulse `overrun_err` and go to FETCH to drain. The partial byte is discarded.
  - After the 8th bit (LSB first) → PARITY when configured, otherwise STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample; a 0 pulses `frame_err`. Go to FETCH in either case.
- **FETCH:** assert `deser_get_en` in the first cycle with `deser_get_rdy` = 1, capturing `deser_data`. Then → IDLE.
  - The byte is written to the output register only if the frame is good (stop = 1, parity OK, no overrun).
  - An output register that is full and not being consumed this cycle → drop the byte and pulse `overrun_err`.
  - If `deser_get_rdy` never rises (partial byte), FETCH exits after `CLKS_PER_BIT` cycles without popping.
- **Output register:**
  - `byte_valid` sets on write and clears on `byte_valid && byte_ready`.
  - Write and consume in the same cycle → the new byte is kept and `byte_valid` stays 1.
- Cycle counter width is clog2(`CLKS_PER_BIT`) + 1 bits and wraps to 0 at each sample point.

## Timing
- **Reset values:** all outputs 0, `byte_out` = 0, FSM in IDLE, synchronizer at 1.
- A falling edge on `rx_line` becomes visible as `rxs` = 0 two or three cycles later; t0 is the first IDLE cycle with `rxs` = 0.
- **Sample points, relative to t0 (with N = `CLKS_PER_BIT`):**
  - Start check at t0 + N/2.
  - Data bit i (i = 0..7) at t0 + N/2 + (i+1)·N.
  - Parity (macro only) at t0 + N/2 + 9N.
  - Stop at the following bit slot.
- FETCH starts the cycle after the stop sample.
- `byte_valid` rises the cycle after the `deser_get_en` cycle.
- A new start is accepted from the cycle FETCH returns to IDLE, which is within the stop bit's second half.
- Reset asserted mid-frame clears immediately: no pulses and no pop.

## Configuration
- `UART_RX_SEQ_PARITY_EN` defined:
  - Adds the PARITY state, sampled one bit slot after bit 7.
  - Even parity over the 8 data bits plus the parity bit.
  - A mismatch pulses `parity_err` in the cycle after the parity sample and drops the byte; the deserializer is still drained.
- Undefined:
  - No PARITY state; stop is sampled directly after bit 7.
  - `parity_err` is tied to 0.

## Test plan
- **Good frame:** reset, send 0xA5 at N = 16 with stop = 1 → 8 `deser_en` pulses carrying 1,0,1,0,0,1,0,1. Then `byte_valid` with `byte_out` = 0xA5, and no error pulses.
- **False start:** a 4-cycle low glitch on an idle line → `busy` returns to 0 after the start check, no `deser_en`, no pulses.
- **Framing error:** send 0x3C with stop = 0 → `frame_err` pulses once, the deserializer is popped, `byte_valid` stays 0.
- **Back-to-back with stalled consumer:**
  - Two frames (0x11, 0x22) with `byte_ready` = 0 → `byte_out` = 0x11 and `overrun_err` pulses once for 0x22.
  - With `byte_ready` = 1 and two frames 0x33, 0x44 → both are delivered in order.
- **Reset mid-frame:** assert `RST` during bit 4 → all outputs 0 immediately. A following 0x5A frame is received correctly.
- **Parity (macro defined):** 0x07 with parity bit 1 → byte delivered; with parity bit 0 → `parity_err` pulses and no byte.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer: start-bit detection, mid-bit sampling and stop-bit check for
// a UART receive path. It pushes each sampled data bit into a byte deserializer
// (EN_recieve/recieve_rx), pops the finished byte (EN_get) and holds it in a
// one-entry valid/ready output register.
// Optional feature: define UART_RX_SEQ_PARITY_EN to add an even-parity bit slot
// between data bit 7 and the stop bit.
module uart_rx_sequencer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rx_line,
    output logic       deser_bit,
    output logic       deser_en,
    input  logic       deser_rdy,
    output logic       deser_get_en,
    input  logic       deser_get_rdy,
    input  logic [7:0] deser_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_SEQ_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_FETCH  = 3'd5
    } state_e;

`ifdef UART_RX_SEQ_PARITY_EN
    // Even parity: data bits plus the parity bit must contain an even number of ones.
    function automatic logic parity_mismatch(input logic acc, input logic par_bit);
        return acc ^ par_bit;
    endfunction
`endif

    logic          rx_meta_q;
    logic          rxs_q;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          bad_q, bad_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          oerr_q, oerr_d;
    logic          perr_q, perr_d;
    logic          push_s;
    logic          push_bit_s;
    logic          get_en_s;
`ifdef UART_RX_SEQ_PARITY_EN
    logic          par_q, par_d;
`endif

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx_line;
            rxs_q     <= rx_meta_q;
        end
    end

    // Next-state, counters, deserializer handshake and output-register update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CW'(1);
        bit_d      = bit_q;
        bad_d      = bad_q;
        byte_d     = byte_q;
        ferr_d     = 1'b0;
        oerr_d     = 1'b0;
        perr_d     = 1'b0;
        push_s     = 1'b0;
        push_bit_s = 1'b0;
        get_en_s   = 1'b0;
`ifdef UART_RX_SEQ_PARITY_EN
        par_d      = par_q;
`endif
        // Consumer handshake; a write below overrides the clear.
        if (valid_q && byte_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                bit_d = 3'd0;
                if (!rxs_q) begin
                    state_d = S_START;
                    bad_d   = 1'b0;
`ifdef UART_RX_SEQ_PARITY_EN
                    par_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    // A line back high at mid start bit is a glitch, not a frame.
                    if (rxs_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    // Push only when the deserializer can take the bit; otherwise
                    // abandon the frame and drain whatever it holds.
                    if (deser_rdy) begin
                        push_s     = 1'b1;
                        push_bit_s = rxs_q;
`ifdef UART_RX_SEQ_PARITY_EN
                        par_d      = par_q ^ rxs_q;
`endif
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_SEQ_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        oerr_d  = 1'b1;
                        bad_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`ifdef UART_RX_SEQ_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = S_STOP;
                    if (parity_mismatch(par_q, rxs_q)) begin
                        perr_d = 1'b1;
                        bad_d  = 1'b1;
                    end else begin
                        perr_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                    if (!rxs_q) begin
                        ferr_d = 1'b1;
                        bad_d  = 1'b1;
                    end else begin
                        ferr_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FETCH: begin
                if (deser_get_rdy) begin
                    get_en_s = 1'b1;
                    cnt_d    = '0;
                    state_d  = S_IDLE;
                    // Only a clean frame reaches the consumer; a full register that
                    // is not draining this cycle loses the new byte.
                    if (!bad_q) begin
                        if (valid_q && !byte_ready) begin
                            oerr_d = 1'b1;
                        end else begin
                            byte_d  = deser_data;
                            valid_d = 1'b1;
                        end
                    end else begin
                        byte_d = byte_q;
                    end
                end else if (cnt_q == FULL_M1) begin
                    // Partial byte never completes; give up without popping.
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters, output register and error pulse registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            bad_q   <= 1'b0;
            byte_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
            perr_q  <= 1'b0;
`ifdef UART_RX_SEQ_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            bad_q   <= bad_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
            perr_q  <= perr_d;
`ifdef UART_RX_SEQ_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign deser_en     = push_s;
    assign deser_bit    = push_bit_s;
    assign deser_get_en = get_en_s;
    assign byte_out     = byte_q;
    assign byte_valid   = valid_q;
    assign frame_err    = ferr_q;
    assign overrun_err  = oerr_q;
    assign parity_err   = perr_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: a behavioural deserializer on the push/pop
// handshake, serial frames driven bit by bit, and scoreboards for the pushed
// bits and the delivered bytes.
module tb_uart_rx_sequencer;

    localparam int N = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic       rx_line;
    logic       deser_bit;
    logic       deser_en;
    logic       deser_rdy;
    logic       deser_get_en;
    logic       deser_get_rdy;
    logic [7:0] deser_data;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int n_push = 0, n_pop = 0, n_deliv = 0, n_ferr = 0, n_oerr = 0, n_perr = 0;
    int s_push, s_pop, s_deliv, s_ferr, s_oerr, s_perr;

    logic       exp_bit_q[$];
    logic [7:0] exp_byte_q[$];

    logic [7:0] m_sh;
    logic [3:0] m_cnt;

    uart_rx_sequencer #(.CLKS_PER_BIT(N)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .rx_line       (rx_line),
        .deser_bit     (deser_bit),
        .deser_en      (deser_en),
        .deser_rdy     (deser_rdy),
        .deser_get_en  (deser_get_en),
        .deser_get_rdy (deser_get_rdy),
        .deser_data    (deser_data),
        .byte_out      (byte_out),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .frame_err     (frame_err),
        .overrun_err   (overrun_err),
        .parity_err    (parity_err),
        .busy          (busy)
    );

    always #5 CLK = ~CLK;

    // Behavioural LSB-first deserializer: ready for bits until 8 are held, then poppable.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_sh  <= 8'd0;
            m_cnt <= 4'd0;
        end else if (deser_get_en) begin
            m_cnt <= 4'd0;
        end else if (deser_en) begin
            m_sh  <= {deser_bit, m_sh[7:1]};
            m_cnt <= m_cnt + 4'd1;
        end
    end
    assign deser_rdy     = (m_cnt != 4'd8);
    assign deser_get_rdy = (m_cnt == 4'd8);
    assign deser_data    = m_sh;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Monitor on the falling edge: scoreboards and pulse counters.
    always @(negedge CLK) begin
        if (!RST) begin
            if (deser_en) begin
                n_push++;
                if (exp_bit_q.size() == 0) chk("unexpected deser_en", 32'd1, 32'd0);
                else chk("deser_bit", {31'd0, deser_bit}, {31'd0, exp_bit_q.pop_front()});
            end
            if (deser_get_en) n_pop++;
            if (frame_err) n_ferr++;
            if (overrun_err) n_oerr++;
            if (parity_err) n_perr++;
            if (byte_valid && byte_ready) begin
                n_deliv++;
                if (exp_byte_q.size() == 0) chk("unexpected byte", {24'd0, byte_out}, 32'd0);
                else chk("byte_out", {24'd0, byte_out}, {24'd0, exp_byte_q.pop_front()});
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic snap();
        s_push = n_push; s_pop = n_pop; s_deliv = n_deliv;
        s_ferr = n_ferr; s_oerr = n_oerr; s_perr = n_perr;
    endtask

    task automatic send_bit(input logic b);
        rx_line = b;
        tick(N);
    endtask

    // Drive one frame; record the expected pushed bits and, if deliver, the byte.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b,
                              input logic deliver);
        $display("frame 0x%02h stop=%0b par=%0b", d, stop_b, par_b);
        for (int i = 0; i < 8; i++) exp_bit_q.push_back(d[i]);
        if (deliver) exp_byte_q.push_back(d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_SEQ_PARITY_EN
        send_bit(par_b);
`endif
        send_bit(stop_b);
        rx_line = 1'b1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, {23'd0, byte_out, byte_valid, busy, deser_en, deser_bit, deser_get_en,
                  frame_err, overrun_err, parity_err}, 32'd0);
    endtask

    initial begin
        rx_line    = 1'b1;
        byte_ready = 1'b1;
        RST        = 1'b1;
        tick(3);
        chk_idle_outputs("reset outputs");
        RST = 1'b0;
        tick(4);
        chk("idle busy", {31'd0, busy}, 32'd0);

        // Good frame 0xA5.
        snap();
        send_frame(8'hA5, 1'b1, ^8'hA5, 1'b1);
        tick(2 * N);
        chk("A5 pushes", n_push - s_push, 8);
        chk("A5 pops", n_pop - s_pop, 1);
        chk("A5 delivered", n_deliv - s_deliv, 1);
        chk("A5 errors", (n_ferr - s_ferr) + (n_oerr - s_oerr) + (n_perr - s_perr), 0);
        chk("A5 busy", {31'd0, busy}, 32'd0);

        // False start: 4-cycle glitch.
        snap();
        rx_line = 1'b0;
        tick(4);
        rx_line = 1'b1;
        chk("glitch busy", {31'd0, busy}, 32'd1);
        tick(N);
        chk("glitch busy end", {31'd0, busy}, 32'd0);
        chk("glitch pushes", n_push - s_push, 0);
        chk("glitch pulses", (n_ferr - s_ferr) + (n_oerr - s_oerr) + (n_pop - s_pop), 0);

        // Framing error 0x3C.
        snap();
        send_frame(8'h3C, 1'b0, ^8'h3C, 1'b0);
        tick(2 * N);
        chk("3C frame_err", n_ferr - s_ferr, 1);
        chk("3C pops", n_pop - s_pop, 1);
        chk("3C valid", {31'd0, byte_valid}, 32'd0);
        chk("3C delivered", n_deliv - s_deliv, 0);
        chk("3C overrun", n_oerr - s_oerr, 0);

        // Back-to-back with stalled consumer.
        snap();
        byte_ready = 1'b0;
        send_frame(8'h11, 1'b1, ^8'h11, 1'b1);
        send_frame(8'h22, 1'b1, ^8'h22, 1'b0);
        tick(2 * N);
        chk("stall valid", {31'd0, byte_valid}, 32'd1);
        chk("stall byte_out", {24'd0, byte_out}, 32'h11);
        chk("stall overrun", n_oerr - s_oerr, 1);
        chk("stall delivered", n_deliv - s_deliv, 0);
        byte_ready = 1'b1;
        tick(2);
        chk("stall drained", n_deliv - s_deliv, 1);
        chk("stall valid end", {31'd0, byte_valid}, 32'd0);

        // Back-to-back with ready consumer.
        snap();
        send_frame(8'h33, 1'b1, ^8'h33, 1'b1);
        send_frame(8'h44, 1'b1, ^8'h44, 1'b1);
        tick(2 * N);
        chk("33/44 delivered", n_deliv - s_deliv, 2);
        chk("33/44 overrun", n_oerr - s_oerr, 0);

        // Reset during bit 4 of 0x96.
        snap();
        for (int i = 0; i < 4; i++) exp_bit_q.push_back(1'((8'h96 >> i) & 8'h01));
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'((8'h96 >> i) & 8'h01));
        rx_line = 1'b0;
        tick(N / 4);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        #1;
        chk_idle_outputs("mid-frame reset outputs");
        rx_line = 1'b1;
        tick(3);
        chk("reset pushes", n_push - s_push, 4);
        chk("reset no pop", n_pop - s_pop, 0);
        chk("reset no pulses", (n_ferr - s_ferr) + (n_oerr - s_oerr) + (n_perr - s_perr), 0);
        exp_bit_q.delete();
        RST = 1'b0;
        tick(N);
        snap();
        send_frame(8'h5A, 1'b1, ^8'h5A, 1'b1);
        tick(2 * N);
        chk("5A delivered", n_deliv - s_deliv, 1);
        chk("5A pushes", n_push - s_push, 8);

`ifdef UART_RX_SEQ_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        tick(2 * N);
        chk("par ok delivered", n_deliv - s_deliv, 1);
        chk("par ok no err", n_perr - s_perr, 0);
        snap();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        tick(2 * N);
        chk("par bad err", n_perr - s_perr, 1);
        chk("par bad delivered", n_deliv - s_deliv, 0);
        chk("par bad pop", n_pop - s_pop, 1);
`else
        chk("parity_err never", n_perr, 0);
`endif

        chk("bytes outstanding", exp_byte_q.size(), 0);
        chk("bits outstanding", exp_bit_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
